// File: rtl/time_align_word_packer.sv
// -----------------------------------------------------------------------------
// time_align_word_packer
//
// Packs WORDS consecutive 6-bit aligned words ({msb[2:0], lsb[2:0]}) into one
// wide packet and queues packets in a DEPTH-entry FIFO. The FIFO drains toward
// the capture/transport logic over a valid/ready handshake. flush_i closes a
// partial packet at the end of a burst.
//
// Optional feature macro: PACKER_PARITY_EN
//   When defined, adds dout_par_o. This is the XOR of the packet payload. It is
//   computed when the packet is pushed and stored in the FIFO with the packet.
//
// Ports:
//   clk_i         clock, rising edge
//   reset_i       asynchronous, active-high reset
//   din_i         aligned word from the alignment stage
//   din_valid_i   din_i valid this cycle
//   din_ready_o   packer accepts din_i this cycle
//   flush_i       close the current partial packet
//   dout_o        packet payload, word k at bits [6k+5:6k]
//   dout_cnt_o    number of valid words in dout_o
//   dout_valid_o  FIFO head valid
//   dout_ready_i  downstream pops the FIFO head
//   dout_par_o    payload parity (PACKER_PARITY_EN only)
// -----------------------------------------------------------------------------
module time_align_word_packer #(
    parameter int WORDS = 4,
    parameter int DEPTH = 2
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [5:0]                     din_i,
    input  logic                           din_valid_i,
    output logic                           din_ready_o,
    input  logic                           flush_i,
    output logic [6*WORDS-1:0]             dout_o,
    output logic [$clog2(WORDS+1)-1:0]     dout_cnt_o,
    output logic                           dout_valid_o,
    input  logic                           dout_ready_i
`ifdef PACKER_PARITY_EN
    ,
    output logic                           dout_par_o
`endif
);

    localparam int CW   = $clog2(WORDS);
    localparam int CNTW = $clog2(WORDS + 1);
    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = 6 * WORDS;
    localparam logic [CW-1:0] LAST_SLOT = CW'(WORDS - 1);

`ifdef PACKER_PARITY_EN
    function automatic logic calc_parity(input logic [PW-1:0] payload);
        return ^payload;
    endfunction
`endif

    logic [CW-1:0]   cnt_r;
    logic [PW-1:0]   pack_r;
    logic [AW:0]     wr_ptr_r;
    logic [AW:0]     rd_ptr_r;
    logic [PW-1:0]   mem_data_r [DEPTH];
    logic [CNTW-1:0] mem_cnt_r  [DEPTH];
`ifdef PACKER_PARITY_EN
    logic            mem_par_r  [DEPTH];
`endif

    logic            empty_s;
    logic            full_s;
    logic            is_last_s;
    logic            din_ready_s;
    logic            accept_s;
    logic            pop_s;
    logic            push_s;
    logic [PW-1:0]   merged_s;
    logic [PW-1:0]   push_data_s;
    logic [CNTW-1:0] push_cnt_s;
    logic [CW-1:0]   cnt_next_s;
    logic [PW-1:0]   pack_next_s;

    // FIFO status. The extra pointer MSB tells full apart from empty.
    always_comb begin
        empty_s = (wr_ptr_r == rd_ptr_r);
        full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    end

    // Insert the incoming word into slot cnt of a copy of the pack register.
    always_comb begin
        merged_s = pack_r;
        for (int k = 0; k < WORDS; k++) begin
            if (CW'(k) == cnt_r) begin
                merged_s[6*k +: 6] = din_i;
            end else begin
                merged_s[6*k +: 6] = pack_r[6*k +: 6];
            end
        end
    end

    // Handshake and push decision. A full FIFO blocks only the transitions
    // that would push: the last word, or any flush. A pop in the same cycle
    // does not free a slot for the push.
    always_comb begin
        is_last_s   = (cnt_r == LAST_SLOT);
        din_ready_s = !(full_s && (is_last_s || flush_i));
        accept_s    = din_valid_i && din_ready_s;
        pop_s       = !empty_s && dout_ready_i;
        push_s      = 1'b0;
        push_data_s = {PW{1'b0}};
        push_cnt_s  = {CNTW{1'b0}};
        cnt_next_s  = cnt_r;
        pack_next_s = pack_r;
        if (accept_s) begin
            if (is_last_s || flush_i) begin
                // The word is included first, then the packet closes.
                push_s      = 1'b1;
                push_data_s = merged_s;
                push_cnt_s  = CNTW'(cnt_r) + CNTW'(1);
                cnt_next_s  = {CW{1'b0}};
                pack_next_s = {PW{1'b0}};
            end else begin
                cnt_next_s  = cnt_r + CW'(1);
                pack_next_s = merged_s;
            end
        end else if (flush_i && (cnt_r != {CW{1'b0}}) && !full_s) begin
            push_s      = 1'b1;
            push_data_s = pack_r;
            push_cnt_s  = CNTW'(cnt_r);
            cnt_next_s  = {CW{1'b0}};
            pack_next_s = {PW{1'b0}};
        end else begin
            cnt_next_s  = cnt_r;
            pack_next_s = pack_r;
        end
    end

    // Word counter, pack register and FIFO pointers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_r    <= {CW{1'b0}};
            pack_r   <= {PW{1'b0}};
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            cnt_r  <= cnt_next_s;
            pack_r <= pack_next_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // FIFO storage. It is cleared on reset so that the head reads zero while the FIFO is empty after reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_r[i] <= {PW{1'b0}};
                mem_cnt_r[i]  <= {CNTW{1'b0}};
`ifdef PACKER_PARITY_EN
                mem_par_r[i]  <= 1'b0;
`endif
            end
        end else if (push_s) begin
            mem_data_r[wr_ptr_r[AW-1:0]] <= push_data_s;
            mem_cnt_r[wr_ptr_r[AW-1:0]]  <= push_cnt_s;
`ifdef PACKER_PARITY_EN
            mem_par_r[wr_ptr_r[AW-1:0]]  <= calc_parity(push_data_s);
`endif
        end
    end

    assign din_ready_o  = din_ready_s;
    assign dout_valid_o = !empty_s;
    assign dout_o       = mem_data_r[rd_ptr_r[AW-1:0]];
    assign dout_cnt_o   = mem_cnt_r[rd_ptr_r[AW-1:0]];
`ifdef PACKER_PARITY_EN
    assign dout_par_o   = mem_par_r[rd_ptr_r[AW-1:0]];
`endif

endmodule
